// File: rtl/node_injector.sv
// Source node for a NoC router's local port: queues generator requests, interleaves
// periodic forward ants (ants win), and presents one packet at a time under i_en.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef CREATE_ANT_PERIOD
`define CREATE_ANT_PERIOD 100
`endif

package noc_pkg;
  localparam int XW    = $clog2(`X_NODES + 1);
  localparam int YW    = $clog2(`Y_NODES + 1);
  localparam int MEM_N = 4;
  localparam int TS_W  = 32;
  localparam int ID_W  = 16;

  typedef struct packed {
    logic [ID_W-1:0]                id;
    logic [XW-1:0]                  x_source;
    logic [YW-1:0]                  y_source;
    logic [XW-1:0]                  x_dest;
    logic [YW-1:0]                  y_dest;
    logic                           measure;
    logic [TS_W-1:0]                timestamp;
    logic                           ant;
    logic                           backward;
    logic [MEM_N-1:0][XW+YW-1:0]    memories;
    logic [$clog2(MEM_N+1)-1:0]     num_memories;
  } packet_t;
endpackage

module node_injector
  import noc_pkg::*;
#(
  parameter int X_LOC       = 0,
  parameter int Y_LOC       = 0,
  parameter int QUEUE_DEPTH = 32,
  parameter int ANT_PERIOD  = `CREATE_ANT_PERIOD,
  parameter int CNT_W       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_gen_val,
  input  logic [$clog2(`X_NODES+1)-1:0]    i_x_dest,
  input  logic [$clog2(`Y_NODES+1)-1:0]    i_y_dest,
  input  logic                             i_measure,
  input  logic                             i_en,
  output packet_t                          o_data,
  output logic                             o_data_val,
  output logic [CNT_W-1:0]                 o_data_count,
  output logic [CNT_W-1:0]                 o_ant_count,
  output logic [CNT_W-1:0]                 o_drop_count,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_queue_level
);
  localparam int NODES = `X_NODES * `Y_NODES;
  localparam int SELF  = Y_LOC * `X_NODES + X_LOC;
  localparam int AW    = $clog2(QUEUE_DEPTH);
  localparam int LW    = $clog2(QUEUE_DEPTH + 1);
  localparam int NW    = $clog2(NODES + 1);
  localparam int TW    = $clog2(ANT_PERIOD);
  localparam logic [NW-1:0] FIRST_IDX = (SELF == 0) ? NW'(1) : NW'(0);

  typedef enum logic [1:0] {EMPTY, HOLD_DATA, HOLD_ANT} state_t;
  state_t state, state_nxt;

  packet_t          fifo_mem [QUEUE_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] cycle_timer;
  logic [TW-1:0]    ant_timer;
  logic             ant_pending;
  logic [NW-1:0]    ant_idx, ant_idx_load;
  logic [ID_W-1:0]  pkt_id;
  logic             full, empty, push, gen_drop, ant_wrap, ant_drop;
  logic             xfer, slot_free, load_ant, pop, data_xfer, ant_xfer;
  packet_t          push_pkt, ant_pkt, pop_pkt;

  // Next destination in node order, wrapping and never targeting ourselves.
  function automatic logic [NW-1:0] next_node(input logic [NW-1:0] idx);
    logic [NW-1:0] n;
    n = (int'(idx) + 1 >= NODES) ? '0 : idx + NW'(1);
    if (int'(n) == SELF) n = (int'(n) + 1 >= NODES) ? '0 : n + NW'(1);
    return n;
  endfunction

  assign full      = (level == LW'(QUEUE_DEPTH));
  assign empty     = (level == '0);
  assign push      = i_gen_val && !full;
  assign gen_drop  = i_gen_val && full;
  assign ant_wrap  = (ant_timer == TW'(ANT_PERIOD - 1));
  assign xfer      = o_data_val && i_en;
  assign slot_free = (state == EMPTY) || xfer;
  assign load_ant  = slot_free && ant_pending;
  assign pop       = slot_free && !ant_pending && !empty;
  assign ant_drop  = ant_wrap && ant_pending && !load_ant;
  // An ant leaving on the same edge a new one loads must not reuse its destination.
  assign ant_idx_load  = ant_xfer ? next_node(ant_idx) : ant_idx;
  assign o_queue_level = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (slot_free) begin
      if (ant_pending)  state_nxt = HOLD_ANT;
      else if (!empty)  state_nxt = HOLD_DATA;
      else              state_nxt = EMPTY;
    end
  end

  always_comb begin
    o_data_val = (state != EMPTY);
    data_xfer  = (state == HOLD_DATA) && i_en;
    ant_xfer   = (state == HOLD_ANT) && i_en;
  end

  always_comb begin
    push_pkt           = '0;
    push_pkt.x_source  = XW'(X_LOC);
    push_pkt.y_source  = YW'(Y_LOC);
    push_pkt.x_dest    = i_x_dest;
    push_pkt.y_dest    = i_y_dest;
    push_pkt.measure   = i_measure;
    push_pkt.timestamp = TS_W'(cycle_timer);
    ant_pkt            = '0;
    ant_pkt.id         = pkt_id;
    ant_pkt.x_source   = XW'(X_LOC);
    ant_pkt.y_source   = YW'(Y_LOC);
    ant_pkt.x_dest     = XW'(int'(ant_idx_load) % `X_NODES);
    ant_pkt.y_dest     = YW'(int'(ant_idx_load) / `X_NODES);
    ant_pkt.timestamp  = TS_W'(cycle_timer);
    ant_pkt.ant        = 1'b1;
    pop_pkt            = fifo_mem[rd_ptr];
    pop_pkt.id         = pkt_id;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_pkt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      cycle_timer  <= '0;
      ant_timer    <= '0;
      ant_pending  <= 1'b0;
      ant_idx      <= FIRST_IDX;
      pkt_id       <= '0;
      o_data       <= '0;
      o_data_count <= '0;
      o_ant_count  <= '0;
      o_drop_count <= '0;
    end else begin
      cycle_timer  <= cycle_timer + CNT_W'(1);
      ant_timer    <= ant_wrap ? '0 : ant_timer + TW'(1);
      ant_pending  <= ant_wrap || (ant_pending && !load_ant);
      level        <= level + LW'(push) - LW'(pop);
      o_data_count <= o_data_count + CNT_W'(data_xfer);
      o_ant_count  <= o_ant_count + CNT_W'(ant_xfer);
      o_drop_count <= o_drop_count + CNT_W'(gen_drop) + CNT_W'(ant_drop);
      if (push)     wr_ptr  <= wr_ptr + AW'(1);
      if (pop)      rd_ptr  <= rd_ptr + AW'(1);
      if (ant_xfer) ant_idx <= ant_idx_load;
      if (load_ant) begin
        o_data <= ant_pkt;
        pkt_id <= pkt_id + ID_W'(1);
      end else if (pop) begin
        o_data <= pop_pkt;
        pkt_id <= pkt_id + ID_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: data packets are checked against a scoreboard
// queue as they transfer; ants are checked against a destination-cycle model.
module tb_node_injector;
  import noc_pkg::*;
  localparam int P  = 100;
  localparam int QD = 32;
  localparam int XN = `X_NODES;
  localparam int NN = `X_NODES * `Y_NODES;

  logic                     clk, reset, i_gen_val, i_measure, i_en;
  logic [XW-1:0]            i_x_dest;
  logic [YW-1:0]            i_y_dest;
  packet_t                  o_data;
  logic                     o_data_val;
  logic [31:0]              o_data_count, o_ant_count, o_drop_count;
  logic [$clog2(QD+1)-1:0]  o_queue_level;

  int      total, bad, cyc, ant_idx_m;
  packet_t exp_q[$];
  bit      kinds[$];
  packet_t snap, mon_e;
  logic [5:0] kv;

  node_injector #(.X_LOC(0), .Y_LOC(0), .QUEUE_DEPTH(QD), .ANT_PERIOD(P), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .i_gen_val(i_gen_val), .i_x_dest(i_x_dest),
    .i_y_dest(i_y_dest), .i_measure(i_measure), .i_en(i_en), .o_data(o_data),
    .o_data_val(o_data_val), .o_data_count(o_data_count), .o_ant_count(o_ant_count),
    .o_drop_count(o_drop_count), .o_queue_level(o_queue_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nxt_node(input int i);
    int n;
    n = (i + 1) % NN;
    if (n == 0) n = 1;
    return n;
  endfunction

  // A transfer happens at the next rising edge whenever val and en are both high here.
  always @(negedge clk) begin
    if (!reset && o_data_val === 1'b1 && i_en === 1'b1) begin
      kinds.push_back(o_data.ant);
      if (o_data.ant === 1'b1) begin
        chk("ant_x_dest", 64'(o_data.x_dest), 64'(ant_idx_m % XN));
        chk("ant_y_dest", 64'(o_data.y_dest), 64'(ant_idx_m / XN));
        chk("ant_source", 64'({o_data.x_source, o_data.y_source}), 64'(0));
        chk("ant_measure", 64'(o_data.measure), 64'(0));
        ant_idx_m = nxt_node(ant_idx_m);
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=data_packet x=%0d y=%0d expected=none", o_data.x_dest, o_data.y_dest);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data_x_dest", 64'(o_data.x_dest), 64'(mon_e.x_dest));
        chk("data_y_dest", 64'(o_data.y_dest), 64'(mon_e.y_dest));
        chk("data_measure", 64'(o_data.measure), 64'(mon_e.measure));
        chk("data_timestamp", 64'(o_data.timestamp), 64'(mon_e.timestamp));
        chk("data_source", 64'({o_data.x_source, o_data.y_source}), 64'(0));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_req(input int x, input int y, input bit m, input bit acc);
    packet_t e;
    i_gen_val = 1'b1;
    i_x_dest  = XW'(x);
    i_y_dest  = YW'(y);
    i_measure = m;
    if (acc) begin
      e = '0;
      e.x_dest = XW'(x);
      e.y_dest = YW'(y);
      e.measure = m;
      e.timestamp = TS_W'(cyc);
      exp_q.push_back(e);
    end
    tick(1);
    i_gen_val = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_gen_val = 1'b0;
    exp_q.delete();
    kinds.delete();
    ant_idx_m = 1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; ant_idx_m = 1;
    reset = 1'b1; i_gen_val = 1'b0; i_x_dest = '0; i_y_dest = '0; i_measure = 1'b0; i_en = 1'b1;
    tick(3);
    chk("rst_val", 64'(o_data_val), 64'(0));
    chk("rst_data_zero", 64'(o_data === '0), 64'(1));
    chk("rst_level", 64'(o_queue_level), 64'(0));
    chk("rst_counts", 64'(o_data_count | o_ant_count | o_drop_count), 64'(0));
    reset = 1'b0;

    // Ants alone: first one after P edges, destinations cycle 1..15 then wrap to 1.
    tick(P);
    chk("t1_not_yet", 64'(o_data_val), 64'(0));
    tick(1);
    chk("t1_val", 64'(o_data_val), 64'(1));
    chk("t1_is_ant", 64'(o_data.ant), 64'(1));
    chk("t1_ts", 64'(o_data.timestamp), 64'(P));
    chk("t1_id", 64'(o_data.id), 64'(0));
    tick(1);
    chk("t1_ant_count", 64'(o_ant_count), 64'(1));
    for (int n = 0; n < 16 * P + 50 && o_ant_count < 16; n++) tick(1);
    chk("t1_ant_count16", 64'(o_ant_count), 64'(16));
    chk("t1_drops", 64'(o_drop_count), 64'(0));
    chk("t1_wrap_idx", 64'(ant_idx_m), 64'(2));

    // Single request at cycle 10.
    do_reset();
    i_en = 1'b1;
    tick(10);
    push_req(3, 2, 1'b1, 1'b1);
    chk("t2_level", 64'(o_queue_level), 64'(1));
    chk("t2_val_early", 64'(o_data_val), 64'(0));
    tick(1);
    chk("t2_val", 64'(o_data_val), 64'(1));
    chk("t2_xd", 64'(o_data.x_dest), 64'(3));
    chk("t2_yd", 64'(o_data.y_dest), 64'(2));
    chk("t2_ts", 64'(o_data.timestamp), 64'(10));
    chk("t2_ant", 64'(o_data.ant), 64'(0));
    tick(1);
    chk("t2_count", 64'(o_data_count), 64'(1));
    chk("t2_val_after", 64'(o_data_val), 64'(0));

    // Back-pressure: 50 requests with i_en low -> 1 held, 32 queued, 17 dropped.
    do_reset();
    i_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      push_req(i % 4, (i / 4) % 4, 1'(i), i < 33);
      if (i == 1) snap = o_data;
      if (i >= 2) chk("t3_stable", 64'(o_data === snap), 64'(1));
    end
    chk("t3_level", 64'(o_queue_level), 64'(QD));
    chk("t3_drops", 64'(o_drop_count), 64'(17));
    chk("t3_val", 64'(o_data_val), 64'(1));
    chk("t3_no_xfer", 64'(o_data_count), 64'(0));
    i_en = 1'b1;
    for (int n = 0; n < 100 && o_data_count < 33; n++) tick(1);
    chk("t3_drained", 64'(o_data_count), 64'(33));
    chk("t3_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("t3_level_end", 64'(o_queue_level), 64'(0));

    // Ant pending with 4 queued packets jumps ahead of the queue.
    do_reset();
    i_en = 1'b0;
    for (int i = 0; i < 5; i++) push_req(i, 3 - i % 4, 1'b0, 1'b1);
    tick(P + 2 - 5);
    chk("t4_level", 64'(o_queue_level), 64'(4));
    chk("t4_hold_data", 64'(o_data.ant), 64'(0));
    kinds.delete();
    i_en = 1'b1;
    for (int n = 0; n < 50 && o_data_count < 5; n++) tick(1);
    chk("t4_data_count", 64'(o_data_count), 64'(5));
    chk("t4_ant_count", 64'(o_ant_count), 64'(1));
    kv = '0;
    foreach (kinds[i]) if (i < 6) kv[i] = kinds[i];
    chk("t4_nxfers", 64'(kinds.size()), 64'(6));
    chk("t4_order", 64'(kv), 64'(6'b000010));

    // Two ant periods blocked: the second ant is dropped.
    do_reset();
    i_en = 1'b0;
    push_req(2, 1, 1'b0, 1'b1);
    tick(2 * P + 3 - 1);
    chk("t5_drop", 64'(o_drop_count), 64'(1));
    chk("t5_no_ant", 64'(o_ant_count), 64'(0));
    kinds.delete();
    i_en = 1'b1;
    tick(10);
    chk("t5_ant_count", 64'(o_ant_count), 64'(1));
    chk("t5_data_count", 64'(o_data_count), 64'(1));
    chk("t5_drop_end", 64'(o_drop_count), 64'(1));
    chk("t5_nxfers", 64'(kinds.size()), 64'(2));
    chk("t5_val", 64'(o_data_val), 64'(0));

    // Asynchronous reset while holding data with 5 queued.
    do_reset();
    i_en = 1'b1;
    push_req(1, 1, 1'b0, 1'b1);
    tick(3);
    chk("t6_pre_count", 64'(o_data_count), 64'(1));
    i_en = 1'b0;
    for (int i = 0; i < 6; i++) push_req(i % 4, 1, 1'b1, 1'b1);
    chk("t6_level", 64'(o_queue_level), 64'(5));
    chk("t6_val", 64'(o_data_val), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("t6_async_val", 64'(o_data_val), 64'(0));
    chk("t6_async_level", 64'(o_queue_level), 64'(0));
    chk("t6_async_count", 64'(o_data_count), 64'(0));
    exp_q.delete();
    ant_idx_m = 1;
    tick(1);
    reset = 1'b0;
    i_en = 1'b1;
    tick(20);
    chk("t6_no_stale", 64'(o_data_count), 64'(0));
    chk("t6_val_end", 64'(o_data_val), 64'(0));
    chk("t6_level_end", 64'(o_queue_level), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/node_injector.md
Name: node_injector

Overview:
- Network-interface source node feeding one router's local input port (port 0): i_data[0], i_data_val[0] and o_en[0] on the router side.
- Buffers traffic-generator requests in a FIFO, stamps them into packet_t and presents them one at a time under the router's enable handshake.
- Periodically inserts forward ant packets, with priority over data, with destinations cycled through every other node.
- Keeps transmit and drop counters for the testbench.

Parameters:
- X_LOC, 0, x coordinate of the attached router; written into x_source.
- Y_LOC, 0, y coordinate of the attached router; written into y_source.
- QUEUE_DEPTH, 32, data FIFO depth in packets; must be a power of 2 and ≥2.
- ANT_PERIOD, `CREATE_ANT_PERIOD, cycles between ant creations; must be ≥2.
- CNT_W, 32, width of the statistics counters and of the cycle timer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_gen_val  in  1  generator request valid; sampled every cycle.
- i_x_dest  in  $clog2(`X_NODES+1)  destination x of the request.
- i_y_dest  in  $clog2(`Y_NODES+1)  destination y of the request.
- i_measure  in  1  copied into packet.measure when the request is pushed.
- i_en  in  1  router input port can accept this cycle (the router's o_en[0]).
- o_data  out  packet_t  packet presented to the router.
- o_data_val  out  1  o_data is valid.
- o_data_count  out  CNT_W  data packets accepted by the router.
- o_ant_count  out  CNT_W  ant packets accepted by the router.
- o_drop_count  out  CNT_W  requests lost to a full FIFO, plus ant creations lost while an ant was already pending.
- o_queue_level  out  $clog2(QUEUE_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - o_data_val=0, o_data='0, all counters=0, o_queue_level=0.
  - FIFO empty, ant_pending=0, cycle timer=0, ant timer=0.
  - ant destination index = 0, or 1 if node 0 is self.
- Cycle timer: +1 every cycle after reset, wraps at 2^CNT_W.
- Push:
  - When i_gen_val=1 and the FIFO is not full, the FIFO stores a packet with: x_source=X_LOC, y_source=Y_LOC, x_dest/y_dest from the inputs, measure=i_measure, timestamp=cycle timer, ant=0, backward=0, all memory fields and num_memories cleared.
  - Fullness is evaluated before that edge's pop: a request arriving while full is dropped (o_drop_count+1), even if a pop happens in the same cycle.
- Ant timer:
  - Counts 0..ANT_PERIOD-1 and wraps.
  - On wrap it sets ant_pending. If ant_pending is already 1, the new ant is discarded and o_drop_count+1.
- Output-register FSM:
  - States: EMPTY, HOLD_DATA, HOLD_ANT.
  - o_data_val=1 exactly in the two HOLD states.
  - Transfer occurs when o_data_val=1 and i_en=1. While i_en=0, o_data must stay bit-stable.
  - The slot is free when the state is EMPTY or a transfer is occurring.
  - On a free slot, load in priority order:
    1. If ant_pending: load the ant → HOLD_ANT, clear ant_pending.
    2. Else if the FIFO is not empty: pop the head → HOLD_DATA.
    3. Else → EMPTY.
  - An ant_pending set on the same edge is not visible until the next edge.
  - Back-to-back: with i_en held at 1, one packet transfers per cycle.
- Ant packet contents:
  - ant=1, backward=0, source = (X_LOC, Y_LOC), timestamp = cycle timer at load, memories cleared, measure=0.
  - Destination = node index → (x = idx % `X_NODES, y = idx / `X_NODES).
  - The index advances on each ant transfer, wraps at `X_NODES*`Y_NODES and skips self.
- id field: a packet-id counter stamps every packet on load into the output register and increments on each load.
- Counters:
  - o_data_count increments on a HOLD_DATA transfer; o_ant_count increments on a HOLD_ANT transfer.
  - All counters wrap.
  - o_queue_level reflects pushes and pops registered at the edge.
- Latency: a request sampled at edge k into an empty FIFO and empty slot gives o_data_val=1 after edge k+1.

Test Plan:
- Reset release, no requests, i_en=1 → first ant appears after ANT_PERIOD edges; o_ant_count=1 after acceptance. Destination cycles through all nodes except self, wrapping.
- Single request (dest 3,2) at cycle 10, i_en=1 → o_data_val after edge 11 with x_dest=3, y_dest=2, timestamp=10, ant=0; o_data_count=1 next edge.
- i_en=0 held for 50 cycles with i_gen_val=1 each cycle → o_data stable. o_queue_level saturates at QUEUE_DEPTH, then o_drop_count grows by 1 per cycle. With QUEUE_DEPTH=32, 50 requests give 1 in the output register, 32 queued, 17 dropped.
- FIFO holding 4 packets when an ant becomes pending → the ant transfers before the remaining FIFO packets, then the data resumes in FIFO order.
- i_en=0 across two ant periods → the second ant is dropped (o_drop_count+1); only one ant is sent when i_en returns.
- reset asserted mid-stream while HOLD_DATA with the FIFO at 5 → o_data_val=0 immediately (asynchronously), level=0, counters=0, no stale packet after release.
